// File: rtl/serdesphy_tx_serializer.sv
// TX parallel-to-serial stage: double-buffered Manchester words shifted out MSB-first, idle pattern otherwise.
// Optional completed-word counter enabled by defining SERDESPHY_TX_SER_WORDCNT_EN.
module serdesphy_tx_serializer #(
  parameter int WORD_W = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD = 16'hAAAA
) (
  input  logic              clk_240m_tx,
  input  logic              rst_240m_tx,
  input  logic              enable,
  input  logic              force_idle,
  input  logic              clr_status,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              serial_data,
  output logic              serial_valid,
  output logic              idle_active,
  output logic              busy,
  output logic              underrun,
  output logic [15:0]       words_sent
);
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {DISABLED, IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] buf_word;
  logic [WORD_W-1:0] shifter;
  logic              buf_valid;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;
  logic              last_bit;
  logic              load_buf;
  logic              underrun_set;

  assign word_ready   = enable && !buf_valid;
  assign accept       = word_valid && word_ready;
  assign last_bit     = (state == SHIFT) && (bit_cnt == '0);
  // A queued word starts either from idle (no alignment) or seamlessly after the last bit.
  assign load_buf     = enable && buf_valid && !force_idle && ((state == IDLE) || last_bit);
  assign underrun_set = enable && last_bit && !buf_valid && !force_idle;
  assign serial_data  = shifter[WORD_W-1];

  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx) state <= DISABLED;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED: state_nxt = IDLE;
        IDLE:     if (load_buf) state_nxt = SHIFT;
        SHIFT:    if (last_bit && !load_buf) state_nxt = IDLE;
        default:  state_nxt = DISABLED;
      endcase
    end
  end

  always_comb begin
    serial_valid = (state == SHIFT);
    idle_active  = (state == IDLE);
    busy         = (state == SHIFT) || buf_valid;
  end

  // Shifter is cleared while disabled so the registered serial output reads 0.
  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || !enable) begin
      shifter   <= '0;
      bit_cnt   <= '0;
      buf_valid <= 1'b0;
    end else begin
      if (load_buf) begin
        shifter <= buf_word;
        bit_cnt <= CNT_LAST;
      end else if ((state == DISABLED) || last_bit) begin
        shifter <= IDLE_WORD;
      end else if (state == IDLE) begin
        shifter <= {shifter[WORD_W-2:0], shifter[WORD_W-1]};
      end else begin
        shifter <= shifter << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (accept)        buf_valid <= 1'b1;
      else if (load_buf) buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (accept) buf_word <= word_in;
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx)       underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (clr_status)   underrun <= 1'b0;
  end

`ifdef SERDESPHY_TX_SER_WORDCNT_EN
  logic        word_done;
  logic [15:0] word_cnt;

  assign word_done = enable && last_bit;

  always_ff @(posedge clk_240m_tx) begin
    if (rst_240m_tx || clr_status)           word_cnt <= '0;
    else if (word_done && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
  end

  assign words_sent = word_cnt;
`else
  assign words_sent = '0;
`endif

endmodule
